// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the writeback source encoding.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MDU
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering MDU results ({rd, data}) ahead of the write port.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the register file write port between the ALU writeback path and buffered MDU
// results, and tracks MDU destinations in flight for decode hazard detection.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [DATA_WIDTH-1:0] mdu_data,
  output logic                  mdu_ready,
  input  logic                  mdu_issue,
  input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [DATA_WIDTH-1:0] wd
);

  localparam int ENTRY_W = REG_ADDR_W + DATA_WIDTH;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  wb_src_e               grant;
  logic                  force_mdu;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [CNT_W-1:0]      starve_cnt;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  assign mdu_ready = !fifo_full;
  assign fifo_push = mdu_valid && mdu_ready;
  assign fifo_pop  = (grant == WB_MDU);
  assign head_rd   = fifo_head[ENTRY_W-1 -: REG_ADDR_W];
  assign head_data = fifo_head[DATA_WIDTH-1:0];

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({mdu_rd, mdu_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // ALU has priority unless the MDU head has lost arbitration STARVE_LIMIT times.
  always_comb begin
    grant      = WB_NONE;
    alu_ready  = 1'b1;
    grant_rd   = '0;
    grant_data = '0;
    force_mdu  = (starve_cnt == CNT_W'(STARVE_LIMIT)) && !fifo_empty;
    if (force_mdu) begin
      grant      = WB_MDU;
      alu_ready  = 1'b0;
      grant_rd   = head_rd;
      grant_data = head_data;
    end else if (alu_valid) begin
      grant      = WB_ALU;
      grant_rd   = alu_rd;
      grant_data = alu_data;
    end else if (!fifo_empty) begin
      grant      = WB_MDU;
      grant_rd   = head_rd;
      grant_data = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite <= 1'b0;
      rd       <= '0;
      wd       <= '0;
    end else if (grant == WB_NONE) begin
      regwrite <= 1'b0;
    end else begin
      regwrite <= (grant_rd != '0);
      rd       <= grant_rd;
      wd       <= grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || grant == WB_MDU) begin
      starve_cnt <= '0;
    end else if (grant == WB_ALU && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Set is applied after clear so a fresh issue to the retiring rd stays busy.
  always_comb begin
    busy_next = busy;
    if (grant == WB_MDU) busy_next[head_rd] = 1'b0;
    if (mdu_issue) busy_next[mdu_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  assign hazard = busy[rs1] | busy[rs2];

  a_mdu_hold: assert property (@(posedge clk) disable iff (!rst)
    (mdu_valid && !mdu_ready) |=> (mdu_valid && $stable(mdu_rd) && $stable(mdu_data)));

  a_issue_busy: assert property (@(posedge clk) disable iff (!rst)
    (mdu_issue && mdu_issue_rd != '0) |=> busy[$past(mdu_issue_rd)]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single-cycle behaviour plus
// hand-written starvation and FIFO-full sequences.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] wd;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(
    .DATA_WIDTH   (32),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .mdu_issue    (mdu_issue),
    .mdu_issue_rd (mdu_issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .hazard       (hazard),
    .regwrite     (regwrite),
    .rd           (rd),
    .wd           (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_aready;
    logic        e_mready;
    logic        e_haz;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid    = v.av;
    alu_rd       = v.ard;
    alu_data     = v.adata;
    mdu_valid    = v.mv;
    mdu_rd       = v.mrd;
    mdu_data     = v.mdata;
    mdu_issue    = v.iss;
    mdu_issue_rd = v.ird;
    rs1          = v.s1;
    rs2          = v.s2;
  endtask

  task automatic idle();
    alu_valid    = 1'b0;
    alu_rd       = 5'd0;
    alu_data     = 32'd0;
    mdu_valid    = 1'b0;
    mdu_rd       = 5'd0;
    mdu_data     = 32'd0;
    mdu_issue    = 1'b0;
    mdu_issue_rd = 5'd0;
    rs1          = 5'd0;
    rs2          = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [4:0]  got_rd [2];
  logic [31:0] got_wd [2];
  int          n_got;

  initial begin
    //              av   ard    adata          mv   mrd    mdata   iss  ird    s1     s2      ar   mr   hz   rw   rd     wd
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1,1'b1,1'b0,1'b1,5'd5, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h00001234};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h00001234};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b1, 5'd7,  5'd7,  5'd0,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h00001234};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd7,  5'd0,  1'b1,1'b1,1'b1,1'b0,5'd0, 32'h00001234};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'd42, 1'b0, 5'd0,  5'd7,  5'd0,  1'b1,1'b1,1'b1,1'b0,5'd0, 32'h00001234};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd7,  5'd0,  1'b1,1'b1,1'b1,1'b1,5'd7, 32'd42};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd7,  5'd0,  1'b1,1'b1,1'b0,1'b0,5'd7, 32'd42};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b1, 5'd0,  5'd0,  5'd0,  1'b1,1'b1,1'b0,1'b0,5'd7, 32'd42};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd0,  5'd0,  1'b1,1'b1,1'b0,1'b0,5'd7, 32'd42};
    vecs[10] = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 32'd0,  1'b1, 5'd12, 5'd0,  5'd12, 1'b1,1'b1,1'b0,1'b1,5'd3, 32'h00000033};
    vecs[11] = '{1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0,  5'd0,  5'd12, 1'b1,1'b1,1'b1,1'b1,5'd4, 32'h00000044};

    // Reset held two edges with every request active.
    rst          = 1'b0;
    alu_valid    = 1'b1;
    alu_rd       = 5'd5;
    alu_data     = 32'h11111111;
    mdu_valid    = 1'b1;
    mdu_rd       = 5'd6;
    mdu_data     = 32'h22222222;
    mdu_issue    = 1'b1;
    mdu_issue_rd = 5'd5;
    rs1          = 5'd5;
    rs2          = 5'd6;
    repeat (2) @(posedge clk);
    #2;
    idle();
    rst       = 1'b1;
    rs1       = 5'd5;
    alu_valid = 1'b1;
    #1;
    checkOutput("rst_regwrite", {31'd0, regwrite}, 32'd0);
    checkOutput("rst_rd", {27'd0, rd}, 32'd0);
    checkOutput("rst_wd", wd, 32'd0);
    checkOutput("rst_hazard", {31'd0, hazard}, 32'd0);
    checkOutput("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    checkOutput("rst_alu_ready", {31'd0, alu_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_aready});
      checkOutput($sformatf("v%0d_mdu_ready", i), {31'd0, mdu_ready}, {31'd0, vecs[i].e_mready});
      checkOutput($sformatf("v%0d_hazard", i), {31'd0, hazard}, {31'd0, vecs[i].e_haz});
      tick();
      checkOutput($sformatf("v%0d_regwrite", i), {31'd0, regwrite}, {31'd0, vecs[i].e_rw});
      checkOutput($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].e_rd});
      checkOutput($sformatf("v%0d_wd", i), wd, vecs[i].e_wd);
    end

    // Starvation: ALU keeps the port for four cycles, then the MDU result is forced.
    doReset();
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'd100;
    mdu_valid = 1'b1;
    mdu_rd    = 5'd9;
    mdu_data  = 32'h99;
    #1;
    checkOutput("sv_alu_ready0", {31'd0, alu_ready}, 32'd1);
    tick();
    checkOutput("sv_rd0", {27'd0, rd}, 32'd3);
    mdu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      alu_data = 32'd100 + 32'(k);
      #1;
      checkOutput($sformatf("sv_alu_ready%0d", k), {31'd0, alu_ready}, 32'd1);
      tick();
      checkOutput($sformatf("sv_rd%0d", k), {27'd0, rd}, 32'd3);
      checkOutput($sformatf("sv_wd%0d", k), wd, 32'd100 + 32'(k));
    end
    alu_data = 32'd105;
    #1;
    checkOutput("sv_forced_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    checkOutput("sv_forced_regwrite", {31'd0, regwrite}, 32'd1);
    checkOutput("sv_forced_rd", {27'd0, rd}, 32'd9);
    checkOutput("sv_forced_wd", wd, 32'h99);
    alu_data = 32'd106;
    #1;
    checkOutput("sv_resume_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    checkOutput("sv_resume_rd", {27'd0, rd}, 32'd3);
    checkOutput("sv_resume_wd", wd, 32'd106);

    // FIFO full while the ALU saturates the port.
    doReset();
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'h300;
    mdu_valid = 1'b1;
    mdu_rd    = 5'd10;
    mdu_data  = 32'hA0;
    tick();
    mdu_rd   = 5'd11;
    mdu_data = 32'hB1;
    #1;
    checkOutput("ff_ready_second", {31'd0, mdu_ready}, 32'd1);
    tick();
    mdu_rd   = 5'd12;
    mdu_data = 32'hC2;
    for (int c = 2; c <= 4; c++) begin
      #1;
      checkOutput($sformatf("ff_full_c%0d", c), {31'd0, mdu_ready}, 32'd0);
      tick();
    end
    #1;
    checkOutput("ff_force_alu_ready", {31'd0, alu_ready}, 32'd0);
    checkOutput("ff_force_mdu_ready", {31'd0, mdu_ready}, 32'd0);
    tick();
    checkOutput("ff_first_rd", {27'd0, rd}, 32'd10);
    checkOutput("ff_first_wd", wd, 32'hA0);
    #1;
    checkOutput("ff_ready_after_pop", {31'd0, mdu_ready}, 32'd1);
    tick();
    mdu_valid = 1'b0;
    n_got = 0;
    for (int c = 0; c < 40 && n_got < 2; c++) begin
      tick();
      if (regwrite && rd != 5'd3) begin
        got_rd[n_got] = rd;
        got_wd[n_got] = wd;
        n_got++;
      end
    end
    checkOutput("ff_retired_count", 32'(n_got), 32'd2);
    if (n_got == 2) begin
      checkOutput("ff_second_rd", {27'd0, got_rd[0]}, 32'd11);
      checkOutput("ff_second_wd", got_wd[0], 32'hB1);
      checkOutput("ff_third_rd", {27'd0, got_rd[1]}, 32'd12);
      checkOutput("ff_third_wd", got_wd[1], 32'hC2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
